sram_port_arbiter: RTL
======================

# sram_port_arbiter

Arbitrates the single-port instruction/data SRAM between the instruction-fetch requester and the load/store requester. Each cycle it grants at most one requester, muxes that requester's address, write data and write enable onto the SRAM port, and returns read data one cycle later tagged to the owner. It replaces fixed fetch/execute phase alternation with request-driven sharing. Data accesses have priority, and an optional starvation guard keeps instruction fetch progressing.

## Interface
- ADDR_W, 12, SRAM word-address width
- DATA_W, 32, SRAM word width
- MAX_DATA_STREAK, 4, maximum consecutive data grants while fetch is waiting (guard build only; legal range 1..15)

- clk  in  1  single clock; SRAM is clocked by the same edge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr stable until if_gnt
- if_addr  in  ADDR_W  fetch word address
- if_gnt  out  1  fetch accepted this cycle (combinational)
- if_rvalid  out  1  fetch read data valid (registered)
- if_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request; held with d_we, d_addr, d_wdata stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data accepted this cycle (combinational)
- d_rvalid  out  1  load data valid (registered)
- d_rdata  out  DATA_W  load data
- sram_address  out  ADDR_W  to SRAM address
- sram_data  out  DATA_W  to SRAM write data
- sram_wren  out  1  to SRAM write enable
- sram_q  in  DATA_W  SRAM read data, valid one cycle after address capture

## Operation
- Grant rules, evaluated combinationally each cycle:
  - Only d_req: grant data.
  - Only if_req: grant fetch.
  - Both: grant data, unless the guard is active (see Configuration).
  - Neither: no grant; sram_address holds the last granted address and sram_wren = 0.
- Exactly one of if_gnt and d_gnt may be high. A grant can be issued every cycle, including back-to-back to the same requester.
- Port muxing: sram_address is the granted address. sram_wren = d_gnt & d_we. sram_data = d_wdata at all times.
- In-flight read tracker: a 2-bit state rd_owner with values NONE, FETCH, LOAD. On each clock edge it is set to:
  - FETCH if if_gnt,
  - LOAD if d_gnt & ~d_we,
  - NONE otherwise (this includes stores).
- Response: if_rvalid = (rd_owner == FETCH) and d_rvalid = (rd_owner == LOAD). Both if_rdata and d_rdata are driven directly from sram_q.
- Stores produce no response. The store is complete at the grant edge.
- Read-after-write: a load or fetch granted in the cycle after a store to the same address returns the new data.

## Timing
- Grant to rvalid latency is exactly 1 cycle. Sustained throughput is 1 access per cycle.
- Requesters sample gnt at the clock edge and may change req, addr or data in the following cycle.
- rvalid is a single-cycle pulse. The bus does not stall, so the requester must accept the data in that cycle.
- Reset values (while rst_n = 0, asynchronously):
  - rd_owner = NONE, so if_rvalid = 0 and d_rvalid = 0.
  - sram_wren = 0, if_gnt = 0, d_gnt = 0.
  - streak counter = 0, sram_address = 0.
- Reset mid-operation: a read granted in the cycle before reset assertion gets no rvalid. After release, the first grant is possible in the first cycle with rst_n = 1.

## Configuration
- Macro: SRAM_PORT_ARB_STARVE_GUARD_EN.
- Defined:
  - A 4-bit saturating streak counter increments on every d_gnt while if_req = 1.
  - The counter clears on if_gnt, or in any cycle with if_req = 0.
  - When streak == MAX_DATA_STREAK and both requests are present, fetch is granted instead of data.
- Not defined: strict data priority. The counter and parameter are unused, and fetch can starve indefinitely.

## Structure
- Package sram_port_arb_pkg holds:
  - the rd_owner enum typedef (NONE, FETCH, LOAD),
  - ADDR_W and DATA_W defaults,
  - the streak counter width constant.
- One sub-module, sram_port_arb_prio, holds the priority and starvation-guard grant logic plus the streak counter. The top level holds the port mux and the rd_owner register.

## Test plan
- Reset: hold rst_n = 0 with both reqs high -> no gnt, no rvalid, sram_wren = 0. Release -> d_gnt in the first cycle.
- Fetch only: SRAM preloaded with word 0x00A0 = 0x2402_0005; if_req with if_addr = 0x0A0 -> if_gnt in cycle 0; cycle 1 gives if_rvalid = 1, if_rdata = 0x2402_0005, d_rvalid = 0.
- Store then load: store d_addr = 0x010, d_wdata = 0xDEAD_BEEF (d_gnt, sram_wren = 1, no rvalid), then load 0x010 next cycle -> d_rvalid one cycle later with 0xDEAD_BEEF.
- Contention, guard off: both reqs high for 10 cycles, data all loads -> 10 d_gnt, 0 if_gnt, 10 d_rvalid pulses.
- Contention, guard on, MAX_DATA_STREAK = 4: both reqs high for 10 cycles -> grant sequence D,D,D,D,I,D,D,D,D,I; each if_rvalid lands one cycle after its if_gnt.
- Reset mid-read: pull rst_n low in the cycle after a fetch grant -> no if_rvalid. After release, a new fetch returns correct data with 1-cycle latency.

Source files
------------

// File: rtl/sram_port_arb_pkg.sv
// Shared types and constants for the instruction/data SRAM port arbiter.
// The optional fetch starvation guard is enabled by SRAM_PORT_ARB_STARVE_GUARD_EN.
package sram_port_arb_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;
  localparam int STREAK_W   = 4;

  // Tracks which requester owns the read data arriving from the SRAM next cycle
  typedef enum logic [1:0] {
    NONE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2
  } rd_owner_t;

endpackage

// File: rtl/sram_port_arb_prio.sv
// Grant decision between fetch and data requesters, with optional starvation guard.
// Guard logic (streak counter) is built only when SRAM_PORT_ARB_STARVE_GUARD_EN is defined.
module sram_port_arb_prio
  import sram_port_arb_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic d_req,
  output logic if_gnt,
  output logic d_gnt
);

`ifdef SRAM_PORT_ARB_STARVE_GUARD_EN

  logic [STREAK_W-1:0] streak_reg;
  logic [STREAK_W-1:0] streak_next;
  logic                starve;

  assign starve = (streak_reg == STREAK_W'(MAX_DATA_STREAK));

  // Data wins unless fetch has been passed over MAX_DATA_STREAK times in a row
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (rst_n) begin
      if (d_req && !(if_req && starve)) begin
        d_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    streak_next = streak_reg;
    if (if_gnt || !if_req) begin
      streak_next = '0;
    end else if (d_gnt && (streak_reg != {STREAK_W{1'b1}})) begin
      streak_next = streak_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_reg <= '0;
    end else begin
      streak_reg <= streak_next;
    end
  end

`else

  // Strict data priority; fetch may wait indefinitely under sustained data traffic
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (rst_n) begin
      if (d_req) begin
        d_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  logic unused_guard;
  assign unused_guard = &{1'b0, clk};
  localparam int unused_max_streak = MAX_DATA_STREAK;

`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between instruction fetch and load/store requesters.
// Define SRAM_PORT_ARB_STARVE_GUARD_EN to bound consecutive data grants while fetch waits.
module sram_port_arbiter
  import sram_port_arb_pkg::*;
#(
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int DATA_W          = DATA_W_DEF,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] sram_address,
  output logic [DATA_W-1:0] sram_data,
  output logic              sram_wren,
  input  logic [DATA_W-1:0] sram_q
);

  rd_owner_t         rd_owner_reg;
  rd_owner_t         rd_owner_next;
  logic [ADDR_W-1:0] last_addr_reg;

  sram_port_arb_prio #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_prio (
    .clk   (clk),
    .rst_n (rst_n),
    .if_req(if_req),
    .d_req (d_req),
    .if_gnt(if_gnt),
    .d_gnt (d_gnt)
  );

  // With no grant the address bus parks on the last granted address
  always_comb begin
    sram_address = last_addr_reg;
    if (d_gnt) begin
      sram_address = d_addr;
    end else if (if_gnt) begin
      sram_address = if_addr;
    end
  end

  assign sram_wren = d_gnt & d_we;
  assign sram_data = d_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_addr_reg <= '0;
    end else begin
      last_addr_reg <= sram_address;
    end
  end

  // Stores complete at the grant edge and never claim the read return slot
  always_comb begin
    rd_owner_next = NONE;
    if (if_gnt) begin
      rd_owner_next = FETCH;
    end else if (d_gnt && !d_we) begin
      rd_owner_next = LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_owner_reg <= NONE;
    end else begin
      rd_owner_reg <= rd_owner_next;
    end
  end

  assign if_rvalid = (rd_owner_reg == FETCH);
  assign d_rvalid  = (rd_owner_reg == LOAD);
  assign if_rdata  = sram_q;
  assign d_rdata   = sram_q;

  a_one_grant : assert property (@(posedge clk) disable iff (!rst_n) !(if_gnt && d_gnt));
  a_wren_gnt  : assert property (@(posedge clk) disable iff (!rst_n) sram_wren |-> d_gnt);

endmodule
